// File: rtl/aes_pkg.sv
// Shared types, constants and byte/column helpers for the iterative AES-128 encryptor.
package aes_pkg;

  typedef enum logic [3:0] {
    WAIT,
    ADD_ROUND,
    SUB_BYTES,
    SHIFT_ROWS,
    MIX_COL0,
    MIX_COL1,
    MIX_COL2,
    MIX_COL3,
    DONE
  } aes_state_e;

  localparam logic [3:0] NR = 4'd10;

  // Indexed by round+1; entries past 10 only feed the unused post-final key update.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    {a0, a1, a2, a3} = c;
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Byte (row r, column c) lives at bits [127-8*(r+4c) -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational AES-128 key schedule step: derives the next round key from the current one.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] next_rk
);

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] w;
  logic [31:0] n0, n1, n2, n3;

  assign {k0, k1, k2, k3} = rk;

  // RotWord then SubWord of the last word, rcon folded into the leading byte.
  assign w = {sub_byte(k3[23:16]) ^ rcon,
              sub_byte(k3[15:8]),
              sub_byte(k3[7:0]),
              sub_byte(k3[31:24])};

  assign n0 = k0 ^ w;
  assign n1 = k1 ^ n0;
  assign n2 = k2 ^ n1;
  assign n3 = k3 ^ n2;

  assign next_rk = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor, one round step per clock, round keys derived on the fly.
//
// state      | meaning
// -----------+------------------------------------------------------------
// WAIT       | idle; Run=1 captures Plaintext/Cipherkey
// ADD_ROUND  | XOR round key, advance key and round; after round 10 -> DONE
// SUB_BYTES  | forward S-box on all 16 bytes
// SHIFT_ROWS | rotate row r left by r bytes; skips MixColumns in round 10
// MIX_COL0-3 | MixColumns on one column per cycle
// DONE       | Ready=1, Ciphertext held; Run=0 returns to WAIT
module aes_encrypt_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         Reset,
  input  logic         Run,
  input  logic [127:0] Plaintext,
  input  logic [127:0] Cipherkey,
  output logic [127:0] Ciphertext,
  output logic         Ready
);

  aes_state_e   state;
  logic [127:0] st;
  logic [127:0] rk;
  logic [3:0]   round;

  logic [7:0]   rcon_sel;
  logic [127:0] next_rk;
  logic [127:0] sub_st;

  assign rcon_sel = RCON[round + 4'd1];

  aes_key_step u_key_step (
    .rk      (rk),
    .rcon    (rcon_sel),
    .next_rk (next_rk)
  );

  always_comb begin
    sub_st = '0;
    for (int i = 0; i < 16; i++) begin
      sub_st[8*i +: 8] = sub_byte(st[8*i +: 8]);
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= WAIT;
      round      <= '0;
      st         <= '0;
      rk         <= '0;
      Ciphertext <= '0;
      Ready      <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (Run) begin
            st    <= Plaintext;
            rk    <= Cipherkey;
            round <= '0;
            state <= ADD_ROUND;
          end
        end
        ADD_ROUND: begin
          st    <= st ^ rk;
          rk    <= next_rk;
          round <= round + 4'd1;
          if (round == NR) begin
            Ciphertext <= st ^ rk;
            Ready      <= 1'b1;
            state      <= DONE;
          end else begin
            state <= SUB_BYTES;
          end
        end
        SUB_BYTES: begin
          st    <= sub_st;
          state <= SHIFT_ROWS;
        end
        SHIFT_ROWS: begin
          st    <= shift_rows(st);
          state <= (round == NR) ? ADD_ROUND : MIX_COL0;
        end
        MIX_COL0: begin
          st[127:96] <= mix_column(st[127:96]);
          state      <= MIX_COL1;
        end
        MIX_COL1: begin
          st[95:64] <= mix_column(st[95:64]);
          state     <= MIX_COL2;
        end
        MIX_COL2: begin
          st[63:32] <= mix_column(st[63:32]);
          state     <= MIX_COL3;
        end
        MIX_COL3: begin
          st[31:0] <= mix_column(st[31:0]);
          state    <= ADD_ROUND;
        end
        DONE: begin
          if (!Run) begin
            Ready <= 1'b0;
            state <= WAIT;
          end
        end
        default: begin
          Ready <= 1'b0;
          state <= WAIT;
        end
      endcase
    end
  end

endmodule
